// File: rtl/result_writer_rgb888.sv
// rtl/result_writer_rgb888.sv - frame result writer: skid FIFO into raster-ordered BRAM writes
// Accepts one frame of result pixels after iStart and writes them to consecutive BRAM addresses.
module result_writer_rgb888 #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 17,
  parameter int OUT_WIDTH  = 38,
  parameter int OUT_HEIGHT = 270,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iStart,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iData,
  output logic              oBusy,
  output logic              oCs,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oData,
  output logic              oDone
);

  localparam int DEPTH  = OUT_WIDTH * OUT_HEIGHT;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic               busy, push, pop;

  always_comb begin
    busy = (state_q != S_RUN) || (fifo_cnt_q == FCNT_W'(FIFO_DEPTH)) ||
           (acc_cnt_q == CNT_W'(DEPTH));
    push = (state_q == S_RUN) && iValid && !busy;
    pop  = (state_q == S_RUN) && iEn && (fifo_cnt_q != '0);

    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d    = S_RUN;
          acc_cnt_d  = '0;
          wr_cnt_d   = '0;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          fifo_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (push) begin
          wr_ptr_d  = wr_ptr_q + PTR_W'(1);
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          wr_d     = 1'b1;
          data_d   = fifo_mem[rd_ptr_q];
          addr_d   = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_cnt_q);
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == CNT_W'(DEPTH - 1)) state_d = S_DONE;
        end
        // Push and pop on the same edge cancel out in the occupancy count.
        case ({push, pop})
          2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
          2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
          default: fifo_cnt_d = fifo_cnt_q;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= S_IDLE;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // FIFO storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge iClk) begin
    if (push) fifo_mem[wr_ptr_q] <= iData;
  end

  assign oBusy = busy;
  assign oCs   = wr_q;
  assign oWe   = wr_q;
  assign oAddr = addr_q;
  assign oData = data_q;
  assign oDone = (state_q == S_DONE);

endmodule

// File: tb/tb_result_writer_rgb888.sv
// tb/tb_result_writer_rgb888.sv - self-checking bench for result_writer_rgb888
// Vector table for reset/backpressure, plus randomized frames against a queue-based reference.
module tb_result_writer_rgb888;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 17;
  localparam int BASE   = 32'h100;
  localparam int FD     = 4;
  localparam int DEPTH  = 38 * 270;

  logic              iClk, iRst, iEn, iStart, iValid;
  logic [DATA_W-1:0] iData;
  logic              oBusy, oCs, oWe, oDone;
  logic [ADDR_W-1:0] oAddr;
  logic [DATA_W-1:0] oData;

  result_writer_rgb888 #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_WIDTH(38), .OUT_HEIGHT(270),
    .BASE_ADDR(BASE), .FIFO_DEPTH(FD)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStart(iStart), .iValid(iValid),
    .iData(iData), .oBusy(oBusy), .oCs(oCs), .oWe(oWe), .oAddr(oAddr),
    .oData(oData), .oDone(oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted beats wait in a queue; each write must take the oldest.
  logic [DATA_W-1:0] m_q[$];
  bit m_run = 0;
  bit exp_wr = 0;
  int m_acc = 0;
  int m_wcnt = 0;
  int frames_done = 0;
  int writes_total = 0;

  always @(negedge iClk) begin
    bit done_now;
    bit busy_m;
    int occ;
    logic [DATA_W-1:0] head;
    if (!iRst) begin
      chk("rst_cs", 32'(oCs), 0);
      chk("rst_we", 32'(oWe), 0);
      chk("rst_busy", 32'(oBusy), 1);
      chk("rst_done", 32'(oDone), 0);
      chk("rst_addr", 32'(oAddr), 0);
      chk("rst_data", 32'(oData), 0);
      m_run = 0; exp_wr = 0; m_acc = 0; m_wcnt = 0;
      m_q.delete();
    end else begin
      done_now = 0;
      chk("write_timing", 32'(oCs), 32'(exp_wr));
      chk("we_vs_cs", 32'(oWe), 32'(oCs));
      if (oCs) begin
        writes_total++;
        if (m_q.size() == 0) begin
          chk("write_without_beat", 32'(m_q.size()), 1);
        end else begin
          head = m_q.pop_front();
          chk("write_data", 32'(oData), 32'(head));
        end
        chk("write_addr", 32'(oAddr), (BASE + m_wcnt) % (1 << ADDR_W));
        if (m_wcnt == DEPTH - 1) begin
          done_now = 1;
          m_run = 0;
        end
        m_wcnt++;
      end
      chk("done_pulse", 32'(oDone), 32'(done_now));
      if (done_now) frames_done++;
      occ = m_acc - m_wcnt;
      busy_m = !m_run || (occ == FD) || (m_acc == DEPTH);
      chk("busy", 32'(oBusy), 32'(busy_m));
      exp_wr = m_run && iEn && (occ > 0);
      if (m_run && iValid && !busy_m) begin
        m_q.push_back(iData);
        m_acc++;
      end
      if (!m_run && !done_now && iStart) begin
        m_run = 1; m_acc = 0; m_wcnt = 0;
        m_q.delete();
      end
    end
  end

  // Upstream source: presents pixel index src_idx, advancing only after a transfer.
  int src_idx = 0;
  bit fire_pending = 0;

  task automatic drive(input logic s, input logic v, input logic e);
    @(posedge iClk);
    #1;
    if (fire_pending) src_idx++;
    iStart = s; iValid = v; iEn = e;
    iData  = DATA_W'(src_idx);
    @(negedge iClk);
    fire_pending = iValid && !oBusy;
    #1;
  endtask

  typedef struct {
    logic s, v, e;
    logic busy, cs, done;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int f0;
    int w0;
    iRst = 1'b0; iStart = 1'b0; iValid = 1'b1; iEn = 1'b0; iData = '0;
    repeat (3) @(negedge iClk);
    #2 iRst = 1'b1;

    for (int i = 0; i < 4; i++) tbl[i] = '{1'b0, 1'b1, 1'(i % 2), 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 10; k++) tbl[5 + k] = '{1'b0, 1'b1, 1'b0, 1'(k >= 4), 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Idle after reset, then iStart with iEn held low: four beats fill the FIFO.
    src_idx = 0;
    f0 = frames_done;
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].s, tbl[i].v, tbl[i].e);
      chk($sformatf("tbl%0d_busy", i), 32'(oBusy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_cs", i), 32'(oCs), 32'(tbl[i].cs));
      chk($sformatf("tbl%0d_we", i), 32'(oWe), 32'(tbl[i].cs));
      chk($sformatf("tbl%0d_done", i), 32'(oDone), 32'(tbl[i].done));
    end
    chk("bp_first_data", 32'(oData), 1);

    // Finish that frame with a 1-in-3 enable tick and bursty valid.
    for (int c = 0; c < 40000 && frames_done == f0; c++)
      drive(1'b0, 1'($urandom_range(0, 7) < 5), 1'(c % 3 == 0));
    chk("sparse_frame_done", 32'(frames_done - f0), 1);
    chk("sparse_frame_writes", 32'(m_wcnt), DEPTH);
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    chk("busy_after_sparse", 32'(oBusy), 1);

    // Full-rate streaming with a stray iStart mid-frame.
    src_idx = 0;
    f0 = frames_done;
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 12000 && frames_done == f0; c++)
      drive(1'(c == 50), 1'b1, 1'b1);
    chk("stream_frame_done", 32'(frames_done - f0), 1);
    chk("stream_frame_writes", 32'(m_wcnt), DEPTH);
    chk("stream_last_addr", 32'(oAddr), BASE + DEPTH - 1);
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    chk("busy_after_stream", 32'(oBusy), 1);
    chk("no_extra_done", 32'(frames_done - f0), 1);

    // Abort with reset after 100 writes.
    src_idx = 0;
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 1000 && m_wcnt < 100; c++) drive(1'b0, 1'b1, 1'b1);
    chk("reached_100_writes", 32'(m_wcnt >= 100), 1);
    #2 iRst = 1'b0;
    #1;
    chk("async_rst_cs", 32'(oCs), 0);
    chk("async_rst_we", 32'(oWe), 0);
    chk("async_rst_busy", 32'(oBusy), 1);
    repeat (2) drive(1'b0, 1'b1, 1'b1);
    #2 iRst = 1'b1;
    w0 = writes_total;
    repeat (6) drive(1'b0, 1'b1, 1'b1);
    chk("no_writes_after_abort", 32'(writes_total - w0), 0);
    chk("busy_after_abort", 32'(oBusy), 1);

    // Second frame must start again at the base address.
    src_idx = 0;
    f0 = frames_done;
    w0 = writes_total;
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 30000 && frames_done == f0; c++)
      drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    chk("restart_frame_done", 32'(frames_done - f0), 1);
    chk("restart_frame_writes", 32'(writes_total - w0), DEPTH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/result_writer_rgb888.md
RESULT_WRITER_RGB888 -- requirements
Module: result_writer_rgb888

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel width in bits (RGB888).
REQ-002 SHALL have parameter ADDR_W, default 17, output-BRAM address width.
REQ-003 SHALL have parameter OUT_WIDTH, default 38, result pixels per line (3x3 valid conv of a 40-wide frame).
REQ-004 SHALL have parameter OUT_HEIGHT, default 270, result lines per frame.
REQ-005 SHALL have parameter BASE_ADDR, default 0, BRAM address of the first result pixel.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, input skid FIFO entries (power of two, >=2).
REQ-007 SHALL derive local DEPTH = OUT_WIDTH*OUT_HEIGHT (10260 at defaults).
REQ-008 iClk  input  1  single clock; all logic on its rising edge.
REQ-009 iRst  input  1  asynchronous active-low reset.
REQ-010 iEn  input  1  clock-enable tick; BRAM writes happen only on enabled cycles.
REQ-011 iStart  input  1  one-cycle pulse that arms the writer for one frame.
REQ-012 iValid  input  1  upstream result pixel valid.
REQ-013 iData  input  DATA_W  upstream result pixel.
REQ-014 oBusy  output  1  backpressure to upstream; a beat transfers only when iValid=1 and oBusy=0.
REQ-015 oCs  output  1  BRAM chip select.
REQ-016 oWe  output  1  BRAM write enable.
REQ-017 oAddr  output  ADDR_W  BRAM address.
REQ-018 oData  output  DATA_W  BRAM write data.
REQ-019 oDone  output  1  one-cycle pulse after the last pixel of the frame is written.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-021 IDLE->RUN on iStart=1, clearing accept count, write count and FIFO; iStart in RUN or DONE is ignored.
REQ-022 RUN->DONE on the edge that issues write number DEPTH-1 (zero-based); DONE->IDLE unconditionally on the next edge.
REQ-023 oDone SHALL be 1 exactly during the DONE state cycle, else 0.
REQ-024 oBusy SHALL be combinational: 1 when state!=RUN, or FIFO count==FIFO_DEPTH, or accept count==DEPTH; else 0.
REQ-025 An accepted beat SHALL be pushed into the FIFO on that edge; beats with oBusy=1 are not captured (upstream holds).
REQ-026 On any edge in RUN where iEn=1 and FIFO is non-empty, SHALL pop the head and register oCs=1, oWe=1, oData=head, oAddr=BASE_ADDR+write count; write count increments.
REQ-027 On every other edge oCs and oWe SHALL register 0; oAddr and oData hold their last values.
REQ-028 Latency: beat captured at edge k into an empty FIFO with iEn=1 at edge k+1 SHALL appear on oCs/oWe/oData during the cycle after edge k+1.
REQ-029 Simultaneous push and pop SHALL leave FIFO count unchanged and preserve order; push when full cannot occur (REQ-024).
REQ-030 Writes SHALL occur in strict raster order with consecutive addresses BASE_ADDR..BASE_ADDR+DEPTH-1; no wrap, no extra writes after DEPTH.
REQ-031 iEn=0 SHALL stall writes only; acceptance continues until FIFO full.
REQ-032 Address arithmetic SHALL be ADDR_W bits unsigned; DEPTH+BASE_ADDR <= 2^ADDR_W is a parameter constraint.

Reset
REQ-033 iRst=0 SHALL asynchronously force state IDLE, FIFO empty, counts 0, oCs=0, oWe=0, oAddr=0, oData=0, oDone=0; oBusy thereby 1.
REQ-034 Reset asserted mid-frame SHALL abort immediately with no further BRAM writes; a new iStart is required after release.

Verification
REQ-035 Reset then idle: iRst=0 then 1, no iStart, iValid=1 -> oBusy=1, oCs=oWe=0, oDone=0, no writes.
REQ-036 Streaming: iStart, iEn=1 constant, iValid=1 every cycle with iData=pixel index -> 10260 writes, oAddr 0..10259, oData=oAddr, oDone one pulse, oBusy=1 afterward.
REQ-037 Backpressure: iEn=0 for 10 cycles after iStart with iValid=1 -> exactly 4 beats accepted, oBusy=1 from 5th cycle, then iEn=1 drains in order with no loss or duplication.
REQ-038 Sparse enable: iEn 1-in-3 (as clk_enable tick), bursty iValid -> every write coincides with iEn edge, order and count preserved.
REQ-039 Mid-frame reset: iRst=0 after 100 writes -> oCs=0 immediately, no writes until next iStart; second frame restarts at BASE_ADDR.
REQ-040 iStart during RUN and BASE_ADDR=0x100 -> second iStart ignored, first write at 0x100, last at 0x100+10259.
